// File: rtl/btn_scan_sched_pkg.sv
// Shared constants for the button scan scheduler: event encoding and default sizing.
package btn_scan_sched_pkg;

    localparam int unsigned DEF_N_BTN      = 4;
    localparam int unsigned DEF_TICK_DIV   = 50000;
    localparam int unsigned DEF_HIST       = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // Event word layout is {id, press}; the press bit is the LSB.
    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

endpackage

// File: rtl/btn_scan_sched_evt_fifo.sv
// Synchronous event FIFO with a registered head word; push+pop are both accepted when full.
module evt_fifo
    import btn_scan_sched_pkg::*;
#(
    parameter int unsigned W     = 3,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         full_c,
    output logic         valid,
    output logic [W-1:0] dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          pop_c;
    logic          push_ok_c;
    logic [CW-1:0] count_n;
    logic [W-1:0]  head_n;

    assign full_c = (count == CW'(DEPTH));

    // Next head: the entry behind the popped one, or the incoming word when it lands on an empty slot.
    always_comb begin
        pop_c     = valid && ready;
        push_ok_c = push && (!full_c || pop_c);
        count_n   = count + CW'(push_ok_c) - CW'(pop_c);
        head_n    = dout;
        if (pop_c) begin
            if (count == CW'(1)) begin
                head_n = din;
            end else begin
                head_n = mem[rd_ptr + AW'(1)];
            end
        end else if (count == CW'(0)) begin
            head_n = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_n;
            valid <= (count_n != CW'(0));
            dout  <= head_n;
        end
    end

endmodule

// File: rtl/btn_scan_sched.sv
// Round-robin debounce engine shared across N_BTN buttons; clean-level changes are queued as events.
module btn_scan_sched
    import btn_scan_sched_pkg::*;
#(
    parameter int unsigned N_BTN      = DEF_N_BTN,
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned HIST       = DEF_HIST,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     msclk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_raw,
    input  logic                     scan_en,
    output logic [N_BTN-1:0]         clean,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_press,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int unsigned ID_W  = $clog2(N_BTN);
    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned EVT_W = ID_W + 1;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  ptr;
    logic [HIST-1:0]  hist [N_BTN];

    logic             tick_c;
    logic [HIST-1:0]  h_c;
    logic             rise_c;
    logic             fall_c;
    logic             push_c;
    logic [EVT_W-1:0] push_word_c;
    logic             fifo_full_c;
    logic             drop_c;
    logic [EVT_W-1:0] head;

    // Decision for the button under the pointer; only one button is evaluated per tick.
    always_comb begin
        tick_c      = scan_en && (cnt == CNT_W'(TICK_DIV - 1));
        h_c         = {hist[ptr][HIST-2:0], sync2[ptr]};
        rise_c      = tick_c && (&h_c) && !clean[ptr];
        fall_c      = tick_c && !(|h_c) && clean[ptr];
        push_c      = rise_c || fall_c;
        push_word_c = {ptr, rise_c ? EVT_PRESS : EVT_RELEASE};
        drop_c      = push_c && fifo_full_c && !(evt_valid && evt_ready);
    end

    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Scan-slot counter and round-robin pointer; both hold while scan_en is low.
    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ptr <= '0;
        end else if (scan_en) begin
            if (tick_c) begin
                cnt <= '0;
                ptr <= (ptr == ID_W'(N_BTN - 1)) ? '0 : ptr + ID_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                hist[i] <= '0;
            end
            clean <= '0;
        end else if (tick_c) begin
            hist[ptr] <= h_c;
            if (rise_c) begin
                clean[ptr] <= 1'b1;
            end else if (fall_c) begin
                clean[ptr] <= 1'b0;
            end
        end
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop_c) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    evt_fifo #(
        .W     (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk    (msclk),
        .rst_n  (rst_n),
        .push   (push_c),
        .din    (push_word_c),
        .ready  (evt_ready),
        .full_c (fifo_full_c),
        .valid  (evt_valid),
        .dout   (head)
    );

    assign evt_id    = head[EVT_W-1:1];
    assign evt_press = head[0];

endmodule
